mac_dot_sequencer: RTL and testbench
====================================

Name: mac_dot_sequencer

Overview:
- Upstream controller for the fixed-point saturating MAC.
- Accepts operand pairs over a valid/ready stream, counts VEC_LEN beats per dot product and clears the MAC accumulator before each vector.
- Drives the MAC operands, inserts zero bubbles on stalls and waits out the MAC pipeline latency.
- Captures the final accumulator value and presents it on a valid/ready result port.

Parameters:
- WIDTH, 16, operand and result width (Q6.9 signed; 1.0 = 0x0200)
- VEC_LEN, 8, beats per dot product (>= 1)
- MAC_LAT, 4, clock edges from a change on mac_a/mac_b until its contribution is visible on mac_acc
- CNT_W, 8, width of the beat and drain counters (must hold max(VEC_LEN, MAC_LAT))

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin one dot product; sampled only in IDLE
- in_valid  in  1  operand pair valid
- in_ready  out  1  sequencer accepts a pair this cycle
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- mac_a  out  WIDTH  registered operand to MAC A
- mac_b  out  WIDTH  registered operand to MAC B
- mac_clr_n  out  1  registered active-low clear to MAC reset pin
- mac_acc  in  WIDTH  MAC accumulator output
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_data  out  WIDTH  captured dot-product result
- out_sat  out  1  out_data equals 0x7FFF or 0x8001 (saturation code)
- busy  out  1  state != IDLE

Behaviour:
- Reset (rst=1 at a clk edge):
  - State goes to IDLE and all counters go to 0.
  - mac_a=mac_b=0, mac_clr_n=0, out_valid=0, out_data=0, out_sat=0, in_ready=0.
  - mac_clr_n stays 0 during reset and through IDLE, so the MAC is held cleared.
  - rst mid-operation abandons the vector immediately. No result is produced.
- Feeding zeros to the MAC is harmless: 0x0000×0x0000 normalises to 0, so bubbles leave the accumulator unchanged.
- States:
  - IDLE:
    - mac_clr_n=0, mac_a=mac_b=0, in_ready=0.
    - start=1 moves to FEED and loads beat_cnt=0.
    - start is ignored in every other state.
  - FEED:
    - mac_clr_n=1, in_ready=1.
    - On in_valid & in_ready: mac_a<=in_a, mac_b<=in_b, beat_cnt++.
    - If in_valid=0: mac_a<=0, mac_b<=0 (bubble).
    - The beat that makes beat_cnt==VEC_LEN moves to DRAIN, and drain_cnt<=MAC_LAT.
    - in_ready is combinational from state only and does not depend on in_valid.
  - DRAIN:
    - in_ready=0, mac_a=mac_b=0.
    - drain_cnt decrements each cycle.
    - When drain_cnt==0: out_data<=mac_acc, out_sat<=(mac_acc==0x7FFF or 0x8001), out_valid<=1, go to OUT.
    - DRAIN lasts exactly MAC_LAT+1 cycles.
  - OUT:
    - mac_clr_n=1, so the accumulator value is preserved.
    - out_valid and out_data are held stable until out_ready=1.
    - On out_valid & out_ready: out_valid<=0, go to IDLE.
    - out_ready=0 is tolerated indefinitely.
- Latency with no bubbles and out_ready=1: start edge, then VEC_LEN FEED cycles, then MAC_LAT+1 DRAIN cycles, then out_valid. For defaults that is 1+8+5 = 14 edges after start.
- Clearing: entering IDLE re-asserts mac_clr_n=0. Every vector therefore starts from acc=0 with an empty MAC pipeline. There is no carry-over between vectors.
- VEC_LEN=1 is legal: one beat, then DRAIN.
- Counters never wrap: beat_cnt tops at VEC_LEN, drain_cnt stops at 0.
- Saturation is the MAC's job. This block only flags it via out_sat.

Test Plan:
- VEC_LEN=4, four beats a=b=0x0200 back-to-back, out_ready=1 -> out_data=0x0800, out_sat=0, out_valid rises exactly 4+MAC_LAT+2 edges after start.
- Same vectors with in_valid low on alternate cycles -> mac_a/mac_b=0 during bubbles, out_data=0x0800, and out_valid is delayed by exactly the number of bubble cycles.
- Two consecutive vectors: first a=0x0200,b=0x0400 ×4 (result 0x1000), then a=0x0200,b=0xFE00 ×4 -> second result 0xF800 (-4.0), proving the clear between vectors.
- a=b=0x7FFF ×4 -> out_data=0x7FFF, out_sat=1. Separately, a=0x7FFF, b=0x8001 -> out_data=0x8001, out_sat=1.
- out_ready held 0 for 10 cycles in OUT -> out_valid and out_data stable, in_ready=0, start ignored. Releasing out_ready gives a single handshake, then IDLE.
- rst=1 asserted mid-FEED after 2 of 4 beats -> next edge: IDLE, mac_clr_n=0, out_valid=0. A following full vector of 0x0200 pairs yields 0x0800 with no residue.

Source files
------------

// File: rtl/mac_dot_sequencer.sv
// -----------------------------------------------------------------------------
// mac_dot_sequencer
//
// Upstream controller for a fixed-point saturating MAC. It collects VEC_LEN
// operand pairs per dot product, forwards them to the MAC and clears the
// accumulator before each vector. After the last beat it waits out the MAC
// pipeline, then captures the accumulator and offers it on a result stream.
//
// Ports
//   clk          clock
//   rst          synchronous active-high reset
//   start_i      begin one dot product (only looked at in IDLE)
//   in_valid_i   operand pair valid
//   in_ready_o   pair accepted this cycle (high throughout FEED)
//   in_a_i       operand A (Q6.9 signed)
//   in_b_i       operand B (Q6.9 signed)
//   mac_a_o      registered operand to MAC A (zero during bubbles/idle)
//   mac_b_o      registered operand to MAC B (zero during bubbles/idle)
//   mac_clr_n_o  registered active-low clear to the MAC
//   mac_acc_i    MAC accumulator output
//   out_valid_o  result valid
//   out_ready_i  consumer accepts result
//   out_data_o   captured dot-product result
//   out_sat_o    result equals one of the two saturation codes
//   busy_o       sequencer is not idle
// -----------------------------------------------------------------------------
module mac_dot_sequencer #(
   parameter int WIDTH   = 16,
   parameter int VEC_LEN = 8,
   parameter int MAC_LAT = 4,
   parameter int CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] in_a_i,
   input  logic [WIDTH-1:0] in_b_i,
   output logic [WIDTH-1:0] mac_a_o,
   output logic [WIDTH-1:0] mac_b_o,
   output logic             mac_clr_n_o,
   input  logic [WIDTH-1:0] mac_acc_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] out_data_o,
   output logic             out_sat_o,
   output logic             busy_o
);

   // Symmetric saturation codes produced by the MAC: +max and -max.
   localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-2){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(VEC_LEN - 1);
   localparam logic [CNT_W-1:0] DRAIN_LD  = CNT_W'(MAC_LAT);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FEED  = 2'd1,
      DRAIN = 2'd2,
      OUT   = 2'd3
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
   logic [CNT_W-1:0] drain_cnt_q, drain_cnt_d;
   logic [WIDTH-1:0] mac_a_q, mac_a_d;
   logic [WIDTH-1:0] mac_b_q, mac_b_d;
   logic             mac_clr_n_q, mac_clr_n_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic             out_sat_q, out_sat_d;

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         beat_cnt_q  <= '0;
         drain_cnt_q <= '0;
         mac_a_q     <= '0;
         mac_b_q     <= '0;
         mac_clr_n_q <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sat_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         beat_cnt_q  <= beat_cnt_d;
         drain_cnt_q <= drain_cnt_d;
         mac_a_q     <= mac_a_d;
         mac_b_q     <= mac_b_d;
         mac_clr_n_q <= mac_clr_n_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sat_q   <= out_sat_d;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      beat_cnt_d  = beat_cnt_q;
      drain_cnt_d = drain_cnt_q;
      // Operands default to zero: a zero pair leaves the accumulator as is,
      // so idle, bubble and drain cycles all feed zeros.
      mac_a_d     = '0;
      mac_b_d     = '0;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sat_d   = out_sat_q;

      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d    = FEED;
               beat_cnt_d = '0;
            end
         end

         FEED: begin
            if (in_valid_i) begin
               mac_a_d    = in_a_i;
               mac_b_d    = in_b_i;
               beat_cnt_d = beat_cnt_q + 1'b1;
               if (beat_cnt_q == LAST_BEAT) begin
                  state_d     = DRAIN;
                  drain_cnt_d = DRAIN_LD;
               end
            end
         end

         DRAIN: begin
            // The last operand pair reaches mac_acc MAC_LAT edges after it
            // was registered; capturing once the counter has reached zero
            // samples it one cycle after it became visible.
            if (drain_cnt_q == '0) begin
               out_data_d  = mac_acc_i;
               out_sat_d   = (mac_acc_i == SAT_POS) || (mac_acc_i == SAT_NEG);
               out_valid_d = 1'b1;
               state_d     = OUT;
            end else begin
               drain_cnt_d = drain_cnt_q - 1'b1;
            end
         end

         OUT: begin
            if (out_ready_i) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase

      // Clear is registered from the next state so it is low for exactly
      // the cycles spent in IDLE and high from the first FEED cycle on.
      mac_clr_n_d = (state_d != IDLE);
   end

   assign in_ready_o  = (state_q == FEED);
   assign busy_o      = (state_q != IDLE);
   assign mac_a_o     = mac_a_q;
   assign mac_b_o     = mac_b_q;
   assign mac_clr_n_o = mac_clr_n_q;
   assign out_valid_o = out_valid_q;
   assign out_data_o  = out_data_q;
   assign out_sat_o   = out_sat_q;

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mac_dot_sequencer
//
// Directed bench for mac_dot_sequencer with VEC_LEN=4, MAC_LAT=4. A small
// behavioural Q6.9 saturating MAC with MAC_LAT edges of latency closes the
// loop from mac_a/mac_b/mac_clr_n back to mac_acc.
// -----------------------------------------------------------------------------
module tb_mac_dot_sequencer;

   localparam int WIDTH   = 16;
   localparam int VEC_LEN = 4;
   localparam int MAC_LAT = 4;
   localparam int CNT_W   = 8;

   logic             clk;
   logic             rst;
   logic             start;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic [WIDTH-1:0] mac_a;
   logic [WIDTH-1:0] mac_b;
   logic             mac_clr_n;
   logic [WIDTH-1:0] mac_acc;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_sat;
   logic             busy;

   int errors = 0;
   int checks = 0;
   int edges;

   mac_dot_sequencer #(
      .WIDTH   (WIDTH),
      .VEC_LEN (VEC_LEN),
      .MAC_LAT (MAC_LAT),
      .CNT_W   (CNT_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start_i     (start),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .in_a_i      (in_a),
      .in_b_i      (in_b),
      .mac_a_o     (mac_a),
      .mac_b_o     (mac_b),
      .mac_clr_n_o (mac_clr_n),
      .mac_acc_i   (mac_acc),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_data_o  (out_data),
      .out_sat_o   (out_sat),
      .busy_o      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ------------------------------------------------------------------
   // Behavioural MAC: product stage plus MAC_LAT-2 delay stages, then the
   // accumulator, so a change on mac_a/mac_b shows on mac_acc after
   // MAC_LAT edges. Symmetric saturation at +/-0x7FFF.
   // ------------------------------------------------------------------
   function automatic logic signed [WIDTH-1:0] sat16(input longint v);
      if (v > 32767)       return 16'sh7FFF;
      else if (v < -32767) return 16'sh8001;
      else                 return WIDTH'(v);
   endfunction

   logic signed [WIDTH-1:0] pipe [MAC_LAT-1];
   logic signed [WIDTH-1:0] acc;
   longint                  prod;

   always_comb prod = (longint'($signed(mac_a)) * longint'($signed(mac_b))) >>> 9;

   always @(posedge clk) begin
      if (mac_clr_n !== 1'b1) begin
         for (int i = 0; i < MAC_LAT - 1; i++) pipe[i] <= '0;
         acc <= '0;
      end else begin
         pipe[0] <= sat16(prod);
         for (int i = 1; i < MAC_LAT - 1; i++) pipe[i] <= pipe[i-1];
         acc <= sat16(longint'(acc) + longint'(pipe[MAC_LAT-2]));
      end
   end

   assign mac_acc = acc;

   // ------------------------------------------------------------------
   // Helpers
   // ------------------------------------------------------------------
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Runs one vector of VEC_LEN identical pairs. With alt set, a bubble
   // precedes every beat. Returns the number of edges from the start edge
   // (counted as 1) to the edge at which out_valid rose.
   task automatic run_vec(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input bit alt, output int n_edges);
      int beats;
      bit bubble;
      beats  = 0;
      bubble = alt;
      start  = 1'b1;
      tick();
      start   = 1'b0;
      n_edges = 1;
      in_a    = a;
      in_b    = b;
      while (beats < VEC_LEN) begin
         in_valid = !bubble;
         check("in_ready_feed", in_ready, 1);
         tick();
         n_edges++;
         if (in_valid) begin
            beats++;
         end else begin
            check("bubble_mac_a", mac_a, 0);
            check("bubble_mac_b", mac_b, 0);
         end
         if (alt) bubble = !bubble;
      end
      in_valid = 1'b0;
      while (!out_valid && n_edges < 200) begin
         tick();
         n_edges++;
      end
      $display("vector a=0x%04h b=0x%04h alt=%0d -> out_data=0x%04h out_sat=%0d after %0d edges",
               a, b, alt, out_data, out_sat, n_edges);
   endtask

   // ------------------------------------------------------------------
   // Directed sequence
   // ------------------------------------------------------------------
   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      out_ready = 1'b1;
      repeat (3) tick();

      // Reset state
      check("rst_mac_a", mac_a, 0);
      check("rst_mac_b", mac_b, 0);
      check("rst_clr_n", mac_clr_n, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_sat", out_sat, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_busy", busy, 0);
      rst = 1'b0;
      tick();
      check("idle_clr_n", mac_clr_n, 0);
      check("idle_busy", busy, 0);

      // Back-to-back unity products: 4 * 1.0 = 4.0
      run_vec(16'h0200, 16'h0200, 1'b0, edges);
      check("t1_latency", edges, 10);
      check("t1_data", out_data, 16'h0800);
      check("t1_sat", out_sat, 0);
      tick();
      check("t1_done_valid", out_valid, 0);
      check("t1_done_busy", busy, 0);
      check("t1_done_clr_n", mac_clr_n, 0);

      // Same vector with a bubble before every beat: 4 extra edges
      run_vec(16'h0200, 16'h0200, 1'b1, edges);
      check("t2_latency", edges, 14);
      check("t2_data", out_data, 16'h0800);
      tick();

      // Two consecutive vectors: 4 * 2.0 then 4 * -1.0
      run_vec(16'h0200, 16'h0400, 1'b0, edges);
      check("t3a_data", out_data, 16'h1000);
      tick();
      run_vec(16'h0200, 16'hFE00, 1'b0, edges);
      check("t3b_data", out_data, 16'hF800);
      check("t3b_sat", out_sat, 0);
      tick();

      // Saturation in both directions
      run_vec(16'h7FFF, 16'h7FFF, 1'b0, edges);
      check("t4a_data", out_data, 16'h7FFF);
      check("t4a_sat", out_sat, 1);
      tick();
      run_vec(16'h7FFF, 16'h8001, 1'b0, edges);
      check("t4b_data", out_data, 16'h8001);
      check("t4b_sat", out_sat, 1);
      tick();

      // Back-pressure on the result port; start must be ignored in OUT
      out_ready = 1'b0;
      run_vec(16'h0200, 16'h0200, 1'b0, edges);
      check("t5_latency", edges, 10);
      for (int i = 0; i < 10; i++) begin
         start = 1'b1;
         tick();
         check("t5_hold_valid", out_valid, 1);
         check("t5_hold_data", out_data, 16'h0800);
         check("t5_hold_in_ready", in_ready, 0);
         check("t5_hold_busy", busy, 1);
      end
      start     = 1'b0;
      out_ready = 1'b1;
      tick();
      check("t5_release_valid", out_valid, 0);
      check("t5_release_busy", busy, 0);
      tick();
      check("t5_after_valid", out_valid, 0);
      check("t5_after_busy", busy, 0);

      // Reset after two of four beats, then a clean vector
      start = 1'b1;
      tick();
      start    = 1'b0;
      in_a     = 16'h0200;
      in_b     = 16'h0200;
      in_valid = 1'b1;
      tick();
      tick();
      check("t6_mid_mac_a", mac_a, 16'h0200);
      in_valid = 1'b0;
      rst      = 1'b1;
      tick();
      check("t6_rst_busy", busy, 0);
      check("t6_rst_clr_n", mac_clr_n, 0);
      check("t6_rst_valid", out_valid, 0);
      check("t6_rst_mac_a", mac_a, 0);
      rst = 1'b0;
      run_vec(16'h0200, 16'h0200, 1'b0, edges);
      check("t6_latency", edges, 10);
      check("t6_data", out_data, 16'h0800);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
